cc_mem_read_responder: RTL

- AXI read-channel responder (AR in, R out), the memory end of the R channel that the cache-controller fill logic consumes.
- Accepts read bursts into a small request queue and waits a programmable latency.
- Streams len+1 64-bit beats with rlast on the final beat.
- Data is a deterministic function of each beat's byte address, so benches can self-check fill results.

---
 rtl/cc_mem_read_responder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cc_mem_read_responder.sv
// cc_mem_read_responder: AXI read-channel responder with a request queue, programmable
// first-beat latency and address-derived beat data ({~addr, addr}).
// Ports: clk/rst (async active-high); AR channel araddr_i/arlen_i/arsize_i/arburst_i/
// arvalid_i/arready_o; R channel rdata_o/rresp_o/rlast_o/rvalid_o/rready_i.
// Optional macro CC_MEM_RSP_STALL_EN: LFSR-driven random delay before each beat.
module cc_mem_read_responder #(
    parameter int LATENCY        = 2,
    parameter int REQ_FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr_i,
    input  logic [3:0]  arlen_i,
    input  logic [2:0]  arsize_i,
    input  logic [1:0]  arburst_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic [63:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rlast_o,
    output logic        rvalid_o,
    input  logic        rready_i
);
    localparam int AW = $clog2(REQ_FIFO_DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, LAT, BURST} state_t;

    state_t        state_q, state_d;
    logic [31:0]   f_addr_q [REQ_FIFO_DEPTH];
    logic [3:0]    f_len_q [REQ_FIFO_DEPTH];
    logic [2:0]    f_size_q [REQ_FIFO_DEPTH];
    logic [1:0]    f_burst_q [REQ_FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   fcnt_q;
    logic          push, pop, illegal;
    logic [31:0]   addr_q, addr_d, wmask, next_addr;
    logic [3:0]    len_q, len_d, beat_q, beat_d;
    logic          wrap_q, wrap_d, err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign arready_o = !rst && (fcnt_q != (AW+1)'(REQ_FIFO_DEPTH));
    assign push      = arvalid_i && arready_o;

    always_ff @(posedge clk) begin
        if (push) begin
            f_addr_q[wr_q]  <= araddr_i;
            f_len_q[wr_q]   <= arlen_i;
            f_size_q[wr_q]  <= arsize_i;
            f_burst_q[wr_q] <= arburst_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
        end else begin
            wr_q   <= push ? wr_q + 1'b1 : wr_q;
            rd_q   <= pop ? rd_q + 1'b1 : rd_q;
            fcnt_q <= fcnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Legality of the head-of-queue request; WRAP needs a power-of-two beat count.
    assign illegal = (f_size_q[rd_q] != 3'd3)
                  || !(f_burst_q[rd_q] == 2'b01 || f_burst_q[rd_q] == 2'b10)
                  || (f_burst_q[rd_q] == 2'b10 && !(f_len_q[rd_q] == 4'd1 || f_len_q[rd_q] == 4'd3
                                                    || f_len_q[rd_q] == 4'd7 || f_len_q[rd_q] == 4'd15));

    assign wmask     = ((32'(len_q) + 32'd1) << 3) - 32'd1;
    assign next_addr = wrap_q ? ((addr_q & ~wmask) | ((addr_q + 32'd8) & wmask)) : addr_q + 32'd8;

`ifdef CC_MEM_RSP_STALL_EN
    logic [7:0] lfsr_q;
    logic       rv_q;
    // A beat may only be raised on a cycle where lfsr[0]==0; rv_q keeps it up until taken.
    assign rvalid_o = (state_q == BURST) && (rv_q || !lfsr_q[0]);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 8'h5A;
            rv_q   <= 1'b0;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            rv_q   <= rvalid_o && !rready_i;
        end
    end
`else
    assign rvalid_o = (state_q == BURST);
`endif

    assign rdata_o = rvalid_o ? {~addr_q, addr_q} : 64'd0;
    assign rresp_o = (rvalid_o && err_q) ? 2'b10 : 2'b00;
    assign rlast_o = (state_q == BURST) && (beat_q == len_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        wrap_d  = wrap_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (fcnt_q != '0) begin
                pop     = 1'b1;
                addr_d  = f_addr_q[rd_q] & ~32'd7;
                len_d   = f_len_q[rd_q];
                beat_d  = '0;
                wrap_d  = f_burst_q[rd_q] == 2'b10;
                err_d   = illegal;
                cnt_d   = CW'(LATENCY);
                state_d = (LATENCY == 0) ? BURST : LAT;
            end
            LAT: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CW'(1)) ? BURST : LAT;
            end
            BURST: if (rvalid_o && rready_i) begin
                addr_d  = next_addr;
                beat_d  = beat_q + 1'b1;
                state_d = (beat_q == len_q) ? IDLE : BURST;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
